coproc_issuer: RTL and testbench

Host-side instruction issuer for the matrix/image coprocessor: the initiator end of the `instruction` / `activate_signal` / `wait_signal` / `data_read` handshake. It buffers 32-bit commands from the host bridge in a command FIFO and issues them one at a time. It tracks the coprocessor busy flag and returns read results (`READ`, `READ_IMAGE`) through a response FIFO. It sits between the HPS bridge logic and the coprocessor top-level.

---
 rtl/coproc_issuer_if.sv | 28 ++
 rtl/coproc_issuer.sv | 201 ++++++++++++++++++++
 tb/tb_coproc_issuer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coproc_issuer_if.sv
// Host-bridge and coprocessor handshake bundle for the instruction issuer.
interface coproc_issuer_if;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] instruction;
  logic [1:0]  activate_signal;
  logic        wait_signal;
  logic [31:0] data_read;
  logic        busy;
  logic        err_timeout;
  logic        err_clear;

  // Environment side: host bridge plus coprocessor
  modport master (
    output cmd_data, cmd_valid, rsp_ready, wait_signal, data_read, err_clear,
    input  cmd_ready, rsp_data, rsp_valid, instruction, activate_signal, busy, err_timeout
  );

  // Issuer side
  modport slave (
    input  cmd_data, cmd_valid, rsp_ready, wait_signal, data_read, err_clear,
    output cmd_ready, rsp_data, rsp_valid, instruction, activate_signal, busy, err_timeout
  );
endinterface

// File: rtl/coproc_issuer.sv
// Buffers host commands, issues them to the coprocessor one at a time and
// returns READ / READ_IMAGE results through a first-word-fall-through FIFO.
module coproc_issuer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned IMG_SETTLE  = 2
) (
  input logic            clk,
  input logic            reset,
  coproc_issuer_if.slave bus
);
  localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int unsigned SW = (IMG_SETTLE > 1) ? $clog2(IMG_SETTLE + 1) : 1;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_READ       = 4'h1;
  localparam logic [3:0] OP_DISCARD    = 4'hD;
  localparam logic [3:0] OP_READ_IMAGE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_SETTLE, S_CAPTURE, S_RELEASE
  } state_t;

  state_t        state, state_n;
  logic [31:0]   cur, cur_n;
  logic [AW-1:0] ack_cnt, ack_cnt_n;
  logic [SW-1:0] settle_cnt, settle_cnt_n;
  logic          err, err_n;

  logic [31:0]   cmd_mem [FIFO_DEPTH];
  logic [PW-1:0] cmd_wr, cmd_wr_n, cmd_rd, cmd_rd_n;
  logic [CW-1:0] cmd_cnt, cmd_cnt_n;
  logic          cmd_push, cmd_pop;

  logic [31:0]   rsp_mem [FIFO_DEPTH];
  logic [PW-1:0] rsp_wr, rsp_wr_n, rsp_rd, rsp_rd_n;
  logic [CW-1:0] rsp_cnt, rsp_cnt_n;
  logic          rsp_push, rsp_pop;

  logic [31:0]   instr_q, instr_n;
  logic          act_q, act_n;
  logic          busy_q, busy_n;
  logic          cmd_ready_q, cmd_ready_n;
  logic          rsp_valid_q, rsp_valid_n;
  logic [31:0]   rsp_data_q, rsp_data_n;

  logic [31:0]   head;
  logic [3:0]    head_op;
  logic          head_is_read;

  assign head         = cmd_mem[cmd_rd];
  assign head_op      = head[3:0];
  assign head_is_read = (head_op == OP_READ) || (head_op == OP_READ_IMAGE);
  assign cmd_push     = bus.cmd_valid && cmd_ready_q;
  assign rsp_pop      = bus.rsp_ready && rsp_valid_q;

  assign bus.instruction     = instr_q;
  assign bus.activate_signal = {1'b0, act_q};
  assign bus.busy            = busy_q;
  assign bus.err_timeout     = err;
  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;

  // Next-state, FIFO bookkeeping and next values of the registered outputs
  always_comb begin
    state_n      = state;
    cur_n        = cur;
    ack_cnt_n    = ack_cnt;
    settle_cnt_n = settle_cnt;
    err_n        = err;
    cmd_pop      = 1'b0;
    rsp_push     = 1'b0;

    if (bus.err_clear) err_n = 1'b0;

    unique case (state)
      S_IDLE: begin
        // Reads reserve a response slot before leaving IDLE, so CAPTURE never overflows
        if ((cmd_cnt != '0) && !bus.wait_signal &&
            (!head_is_read || (rsp_cnt != CW'(FIFO_DEPTH)))) begin
          cmd_pop = 1'b1;
          cur_n   = head;
          if ((head_op == OP_NOP) || (head_op == OP_DISCARD)) begin
            state_n = S_IDLE;
          end else if (head_op == OP_READ_IMAGE) begin
            state_n      = S_SETTLE;
            settle_cnt_n = '0;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_n   = S_WAIT_ACK;
        ack_cnt_n = '0;
      end
      S_WAIT_ACK: begin
        if (bus.wait_signal) begin
          state_n = S_WAIT_DONE;
        end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_RELEASE;
        end else begin
          ack_cnt_n = ack_cnt + AW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!bus.wait_signal) state_n = (cur[3:0] == OP_READ) ? S_CAPTURE : S_RELEASE;
      end
      S_SETTLE: begin
        if (settle_cnt == SW'(IMG_SETTLE - 1)) state_n = S_CAPTURE;
        else settle_cnt_n = settle_cnt + SW'(1);
      end
      S_CAPTURE: begin
        rsp_push = 1'b1;
        state_n  = S_RELEASE;
      end
      S_RELEASE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase

    cmd_wr_n = cmd_push ? cmd_wr + PW'(1) : cmd_wr;
    cmd_rd_n = cmd_pop  ? cmd_rd + PW'(1) : cmd_rd;
    unique case ({cmd_push, cmd_pop})
      2'b10:   cmd_cnt_n = cmd_cnt + CW'(1);
      2'b01:   cmd_cnt_n = cmd_cnt - CW'(1);
      default: cmd_cnt_n = cmd_cnt;
    endcase

    rsp_wr_n = rsp_push ? rsp_wr + PW'(1) : rsp_wr;
    rsp_rd_n = rsp_pop  ? rsp_rd + PW'(1) : rsp_rd;
    unique case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_n = rsp_cnt + CW'(1);
      2'b01:   rsp_cnt_n = rsp_cnt - CW'(1);
      default: rsp_cnt_n = rsp_cnt;
    endcase

    // Instruction bus is held from ISSUE/SETTLE through CAPTURE, zero otherwise
    instr_n = (state_n inside {S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_SETTLE, S_CAPTURE})
              ? cur_n : 32'h0;
    act_n       = (state_n == S_ISSUE);
    busy_n      = (state_n != S_IDLE) || (cmd_cnt_n != '0);
    cmd_ready_n = (cmd_cnt_n != CW'(FIFO_DEPTH));
    rsp_valid_n = (rsp_cnt_n != '0);

    // Head bypass: the word being captured becomes the head when it is the only entry
    if (rsp_cnt_n == '0)                         rsp_data_n = 32'h0;
    else if (rsp_push && (rsp_wr == rsp_rd_n))   rsp_data_n = bus.data_read;
    else                                         rsp_data_n = rsp_mem[rsp_rd_n];
  end

  // State, control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= 32'h0;
      ack_cnt     <= '0;
      settle_cnt  <= '0;
      err         <= 1'b0;
      cmd_wr      <= '0;
      cmd_rd      <= '0;
      cmd_cnt     <= '0;
      rsp_wr      <= '0;
      rsp_rd      <= '0;
      rsp_cnt     <= '0;
      instr_q     <= 32'h0;
      act_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      ack_cnt     <= ack_cnt_n;
      settle_cnt  <= settle_cnt_n;
      err         <= err_n;
      cmd_wr      <= cmd_wr_n;
      cmd_rd      <= cmd_rd_n;
      cmd_cnt     <= cmd_cnt_n;
      rsp_wr      <= rsp_wr_n;
      rsp_rd      <= rsp_rd_n;
      rsp_cnt     <= rsp_cnt_n;
      instr_q     <= instr_n;
      act_q       <= act_n;
      busy_q      <= busy_n;
      cmd_ready_q <= cmd_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
    end
  end

  // FIFO storage writes
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr] <= bus.cmd_data;
    if (rsp_push) rsp_mem[rsp_wr] <= bus.data_read;
  end
endmodule

// File: tb/tb_coproc_issuer.sv
// Scoreboard bench for coproc_issuer with a small coprocessor responder model.
module tb_coproc_issuer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coproc_issuer_if bus ();

  coproc_issuer #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(4), .IMG_SETTLE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          passed = 0;
  int          strobe_seen = 0;
  int          rsp_seen = 0;
  logic [31:0] exp_strobe [$];
  logic [31:0] exp_rsp [$];
  logic        ack_en = 1'b1;
  logic        xor_mode = 1'b0;
  logic        prev_act = 1'b0;
  int          busy_cnt;
  bit          saw_not_ready;
  bit          pushes_done;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Coprocessor model: busy for 5 cycles after each strobe; image reads return a fixed word
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wait_signal <= 1'b0;
      bus.data_read   <= 32'h0;
      busy_cnt        <= 0;
    end else begin
      if (ack_en && bus.activate_signal[0]) begin
        bus.wait_signal <= 1'b1;
        busy_cnt        <= 5;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) bus.wait_signal <= 1'b0;
      end
      if (bus.instruction[3:0] == 4'hF) bus.data_read <= 32'hCAFE_BABE;
      else if (xor_mode)                bus.data_read <= bus.instruction ^ 32'hA5A5_0000;
      else                              bus.data_read <= 32'h0000_1234;
    end
  end

  // Strobe monitor: each strobe must match the next expected instruction
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.activate_signal[0]) begin
        strobe_seen++;
        check("strobe_single", 32'(prev_act), 32'd0);
        check("strobe_wait_low", 32'(bus.wait_signal), 32'd0);
        if (exp_strobe.size() == 0) begin
          checks++;
          $display("FAIL strobe_unexpected: instruction 0x%08h, none expected", bus.instruction);
        end else begin
          check("strobe_instr", bus.instruction, exp_strobe.pop_front());
        end
      end
      check("act_bit1", 32'(bus.activate_signal[1]), 32'd0);
      prev_act = bus.activate_signal[0];
    end else begin
      prev_act = 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on every accepted response
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.rsp_valid && bus.rsp_ready) begin
      rsp_seen++;
      if (exp_rsp.size() == 0) begin
        checks++;
        $display("FAIL rsp_unexpected: rsp_data 0x%08h, none expected", bus.rsp_data);
      end else begin
        check("rsp_data", bus.rsp_data, exp_rsp.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_cmd(input logic [31:0] w);
    bit acc = 1'b0;
    int n = 0;
    bus.cmd_data  = w;
    bus.cmd_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      step();
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for word 0x%08h", w);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      done = !bus.busy && !bus.rsp_valid;
      step();
      n++;
    end
    if (!done) begin
      checks++;
      $display("FAIL idle_timeout: busy=%0b rsp_valid=%0b after %0d cycles", bus.busy, bus.rsp_valid, budget);
    end
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobe_seen < target && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, r0, k;
    logic [31:0] w;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 32'h0;
    bus.rsp_ready = 1'b1;
    bus.err_clear = 1'b0;
    reset = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_instruction", bus.instruction, 32'h0);
    check("rst_activate", 32'(bus.activate_signal), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_err", 32'(bus.err_timeout), 32'h0);
    step();
    reset = 1'b0;
    step();

    // Write then read
    s0 = strobe_seen; r0 = rsp_seen;
    exp_strobe.push_back(32'h0012_3452);
    push_cmd(32'h0012_3452);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.activate_signal[0] && k == 0) k = i;
    end
    check("issue_latency", 32'(k), 32'd2);
    step();
    exp_strobe.push_back(32'h0012_3451);
    exp_rsp.push_back(32'h0000_1234);
    push_cmd(32'h0012_3451);
    wait_idle(200);
    check("wr_strobes", 32'(strobe_seen - s0), 32'd2);
    check("wr_rsps", 32'(rsp_seen - r0), 32'd1);

    // READ_IMAGE: no strobe, fixed settle latency, bus released after capture
    s0 = strobe_seen;
    exp_rsp.push_back(32'hCAFE_BABE);
    push_cmd(32'h0000_0A5F);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (i == 2) check("img_instr_held", bus.instruction, 32'h0000_0A5F);
      if (bus.rsp_valid) begin
        k = i;
        check("img_instr_release", bus.instruction, 32'h0);
      end
    end
    check("img_latency", 32'(k), 32'd5);
    step();
    wait_idle(100);
    check("img_no_strobe", 32'(strobe_seen - s0), 32'd0);

    // Acknowledge timeout with ACK_TIMEOUT = 4
    ack_en = 1'b0;
    exp_strobe.push_back(32'h0000_0103);
    push_cmd(32'h0000_0103);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 6) begin
        check("to_err_before", 32'(bus.err_timeout), 32'h0);
        check("to_instr_held", bus.instruction, 32'h0000_0103);
      end
      if (i == 7) begin
        check("to_err_set", 32'(bus.err_timeout), 32'h1);
        check("to_instr_release", bus.instruction, 32'h0);
      end
      if (i == 8) check("to_idle", 32'(bus.busy), 32'h0);
    end
    step();
    repeat (3) step();
    @(negedge clk);
    check("to_err_sticky", 32'(bus.err_timeout), 32'h1);
    step();
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    @(negedge clk);
    check("to_err_cleared", 32'(bus.err_timeout), 32'h0);
    step();
    ack_en = 1'b1;

    // Backpressure: response FIFO full holds further reads
    bus.rsp_ready = 1'b0;
    xor_mode = 1'b1;
    s0 = strobe_seen; r0 = rsp_seen;
    saw_not_ready = 1'b0;
    pushes_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] pw;
          pw = 32'h0000_1001 + 32'(i) * 32'h100;
          exp_strobe.push_back(pw);
          exp_rsp.push_back(pw ^ 32'hA5A5_0000);
          push_cmd(pw);
        end
        pushes_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!bus.cmd_ready) saw_not_ready = 1'b1;
      step();
    end
    check("bp_cmd_ready_dropped", 32'(saw_not_ready), 32'h1);
    check("bp_pushes_done", 32'(pushes_done), 32'h1);
    check("bp_four_issued", 32'(strobe_seen - s0), 32'd4);
    check("bp_no_rsp_popped", 32'(rsp_seen - r0), 32'd0);
    check("bp_busy", 32'(bus.busy), 32'h1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    wait_strobes(s0 + 5, 40);
    check("bp_fifth_issued", 32'(strobe_seen - s0), 32'd5);
    repeat (30) step();
    check("bp_sixth_held", 32'(strobe_seen - s0), 32'd5);
    bus.rsp_ready = 1'b1;
    wait_idle(300);
    check("bp_all_strobes", 32'(strobe_seen - s0), 32'd6);
    check("bp_all_rsps", 32'(rsp_seen - r0), 32'd6);

    // Reset during WAIT_DONE of a MUL
    xor_mode = 1'b0;
    s0 = strobe_seen;
    exp_strobe.push_back(32'h0000_0205);
    push_cmd(32'h0000_0205);
    wait_strobes(s0 + 1, 20);
    push_cmd(32'h0000_0303);
    @(negedge clk);
    check("mr_wait_high", 32'(bus.wait_signal), 32'h1);
    check("mr_instr_held", bus.instruction, 32'h0000_0205);
    #1 reset = 1'b1;
    #1;
    check("mr_instruction", bus.instruction, 32'h0);
    check("mr_activate", 32'(bus.activate_signal), 32'h0);
    check("mr_busy", 32'(bus.busy), 32'h0);
    check("mr_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("mr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    exp_strobe.delete();
    step();
    step();
    reset = 1'b0;
    step();
    s0 = strobe_seen;
    exp_strobe.push_back(32'h0000_0407);
    push_cmd(32'h0000_0407);
    wait_idle(100);
    check("mr_after_reset_strobe", 32'(strobe_seen - s0), 32'd1);

    // Discarded opcode then 20 alternating SUM / READ with pointer wrap
    xor_mode = 1'b1;
    s0 = strobe_seen; r0 = rsp_seen;
    push_cmd(32'h0000_000D);
    for (int i = 0; i < 20; i++) begin
      w = 32'h00AB_0000 | (32'(i) << 8) | (((i % 2) == 0) ? 32'h3 : 32'h1);
      exp_strobe.push_back(w);
      if ((i % 2) == 1) exp_rsp.push_back(w ^ 32'hA5A5_0000);
      push_cmd(w);
    end
    wait_idle(1000);
    check("wrap_strobes", 32'(strobe_seen - s0), 32'd20);
    check("wrap_rsps", 32'(rsp_seen - r0), 32'd10);

    check("end_strobe_queue", 32'(exp_strobe.size()), 32'd0);
    check("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
